// File: rtl/calendar_ctrl.sv
// ----------------------------------------------------------------------------
// calendar_ctrl
//
// Calendar sequencer for the digital clock. Advances day / month / year on a
// one-cycle end-of-day tick, with days-per-month and leap years.
// A three-field set-mode FSM (RUN -> SET_DAY -> SET_MONTH -> SET_YEAR -> RUN),
// driven by debounced mode/inc pulses, lets the user edit the date.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst_n       synchronous active-low reset
//   en          global enable; low freezes all state and silences ticks
//   day_tick    one-cycle end-of-day pulse
//   mode_btn    one-cycle pulse, steps the set-mode field
//   inc_btn     one-cycle pulse, increments the selected field (with wrap)
//   day         current day, 1..max_day
//   month       current month, 1..12
//   year        current year offset (year = 2000 + offset), 0..YEAR_LAST
//   max_day     days in current month, combinational from month/year
//   month_tick  one-cycle pulse on month rollover
//   year_tick   one-cycle pulse on year rollover
//   set_mode    high in any SET state
//   edit_field  0 none, 1 day, 2 month, 3 year
// ----------------------------------------------------------------------------
module calendar_ctrl #(
    parameter int YEAR_W    = 7,
    parameter int YEAR_LAST = 99
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              day_tick,
    input  logic              mode_btn,
    input  logic              inc_btn,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [4:0]        max_day,
    output logic              month_tick,
    output logic              year_tick,
    output logic              set_mode,
    output logic [1:0]        edit_field
);

    // State encoding doubles as the edit_field value.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_DAY   = 2'd1,
        SET_MONTH = 2'd2,
        SET_YEAR  = 2'd3
    } state_t;

    localparam logic [YEAR_W-1:0] YEAR_MAX = YEAR_W'(YEAR_LAST);
    localparam logic [YEAR_W-1:0] YEAR_ONE = YEAR_W'(1);

    state_t state;
    state_t state_next;

    // Only 2000..2099 is representable, so the low two bits of the offset
    // decide leap years; the century exception never applies.
    function automatic logic [4:0] days_in_month(input logic [3:0] m,
                                                 input logic [1:0] yl);
        logic [4:0] d;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:                    d = (yl == 2'd0) ? 5'd29 : 5'd28;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    function automatic state_t mode_step(input state_t s);
        state_t n;
        case (s)
            RUN:       n = SET_DAY;
            SET_DAY:   n = SET_MONTH;
            SET_MONTH: n = SET_YEAR;
            default:   n = RUN;
        endcase
        return n;
    endfunction

    assign max_day    = days_in_month(month, year[1:0]);
    assign state_next = mode_step(state);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            day        <= 5'd1;
            month      <= 4'd1;
            year       <= '0;
            month_tick <= 1'b0;
            year_tick  <= 1'b0;
            set_mode   <= 1'b0;
            edit_field <= 2'd0;
        end else if (!en) begin
            month_tick <= 1'b0;
            year_tick  <= 1'b0;
        end else begin
            month_tick <= 1'b0;
            year_tick  <= 1'b0;

            if (mode_btn) begin
                state      <= state_next;
                set_mode   <= (state_next != RUN);
                edit_field <= state_next;
            end

            // A month/year edit can leave day beyond the new month length;
            // pulling it back takes priority over any tick or increment.
            if (day > max_day) begin
                day <= max_day;
            end else if (state == RUN) begin
                if (day_tick) begin
                    if (day < max_day) begin
                        day <= day + 5'd1;
                    end else begin
                        day        <= 5'd1;
                        month_tick <= 1'b1;
                        if (month < 4'd12) begin
                            month <= month + 4'd1;
                        end else begin
                            month     <= 4'd1;
                            year_tick <= 1'b1;
                            year      <= (year == YEAR_MAX) ? '0 : year + YEAR_ONE;
                        end
                    end
                end
            end else if (inc_btn && !mode_btn) begin
                // Edits wrap silently and never raise rollover ticks.
                case (state)
                    SET_DAY:   day   <= (day >= max_day) ? 5'd1 : day + 5'd1;
                    SET_MONTH: month <= (month >= 4'd12) ? 4'd1 : month + 4'd1;
                    default:   year  <= (year >= YEAR_MAX) ? '0 : year + YEAR_ONE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calendar_ctrl.sv
module tb_calendar_ctrl;

    localparam int YEAR_W = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              day_tick;
    logic              mode_btn;
    logic              inc_btn;
    logic [4:0]        day;
    logic [3:0]        month;
    logic [YEAR_W-1:0] year;
    logic [4:0]        max_day;
    logic              month_tick;
    logic              year_tick;
    logic              set_mode;
    logic [1:0]        edit_field;

    int n_checks = 0;
    int n_pass   = 0;

    calendar_ctrl #(.YEAR_W(YEAR_W), .YEAR_LAST(99)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .day_tick   (day_tick),
        .mode_btn   (mode_btn),
        .inc_btn    (inc_btn),
        .day        (day),
        .month      (month),
        .year       (year),
        .max_day    (max_day),
        .month_tick (month_tick),
        .year_tick  (year_tick),
        .set_mode   (set_mode),
        .edit_field (edit_field)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic tick();
        day_tick = 1'b1;
        cycle();
        day_tick = 1'b0;
    endtask

    task automatic mode(input int n);
        for (int i = 0; i < n; i++) begin
            mode_btn = 1'b1;
            cycle();
            mode_btn = 1'b0;
        end
    endtask

    task automatic inc(input int n);
        for (int i = 0; i < n; i++) begin
            inc_btn = 1'b1;
            cycle();
            inc_btn = 1'b0;
        end
    endtask

    // From reset: set month and year first (day=1 so nothing clamps),
    // then go around again and set the day within the final month.
    task automatic set_date(input int d, input int m, input int y);
        do_reset();
        mode(2);          // SET_MONTH
        inc(m - 1);
        mode(1);          // SET_YEAR
        inc(y);
        mode(2);          // RUN -> SET_DAY
        inc(d - 1);
        mode(3);          // back to RUN
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; day_tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
        cycle();

        // Reset state
        do_reset();
        check("rst_day",   day, 1);
        check("rst_month", month, 1);
        check("rst_year",  year, 0);
        check("rst_max",   max_day, 31);
        check("rst_mt",    month_tick, 0);
        check("rst_yt",    year_tick, 0);
        check("rst_set",   set_mode, 0);
        check("rst_field", edit_field, 0);

        // January: 30 ticks walk the day up, 31st rolls into February
        for (int i = 1; i <= 30; i++) begin
            tick();
            check("jan_day", day, i + 1);
            check("jan_mt",  month_tick, 0);
        end
        tick();
        check("jan_roll_day",   day, 1);
        check("jan_roll_month", month, 2);
        check("jan_roll_mt",    month_tick, 1);
        check("jan_roll_yt",    year_tick, 0);
        cycle();
        check("jan_mt_drop",    month_tick, 0);

        // Feb 28 of non-leap year 2003
        set_date(28, 2, 3);
        check("feb3_day",  day, 28);
        check("feb3_year", year, 3);
        check("feb3_max",  max_day, 28);
        tick();
        check("feb3_day_roll",   day, 1);
        check("feb3_month_roll", month, 3);
        check("feb3_mt",         month_tick, 1);

        // Feb 28 of leap year 2004
        set_date(28, 2, 4);
        check("feb4_max", max_day, 29);
        tick();
        check("feb4_day29",   day, 29);
        check("feb4_month2",  month, 2);
        check("feb4_mt0",     month_tick, 0);
        tick();
        check("feb4_day_roll",   day, 1);
        check("feb4_month_roll", month, 3);

        // Dec 31 2099 -> Jan 1 2000
        set_date(31, 12, 99);
        check("dec_day",  day, 31);
        check("dec_year", year, 99);
        tick();
        check("ny_day",   day, 1);
        check("ny_month", month, 1);
        check("ny_year",  year, 0);
        check("ny_mt",    month_tick, 1);
        check("ny_yt",    year_tick, 1);
        cycle();
        check("ny_mt_drop", month_tick, 0);
        check("ny_yt_drop", year_tick, 0);

        // Set-mode walk with clamp: year=1, day=31, month -> 2
        do_reset();
        mode(3);
        inc(1);
        mode(1);
        check("sm_run_year", year, 1);
        mode(1);
        check("sm_field_day", edit_field, 1);
        check("sm_set_on",    set_mode, 1);
        inc(30);
        check("sm_day31", day, 31);
        mode(1);
        check("sm_field_month", edit_field, 2);
        inc(1);
        check("sm_month2",       month, 2);
        check("sm_preclamp_day", day, 31);
        check("sm_preclamp_max", max_day, 28);
        check("sm_edit_mt",      month_tick, 0);
        cycle();
        check("sm_clamp_day", day, 28);
        mode(2);
        check("sm_back_run",   set_mode, 0);
        check("sm_back_field", edit_field, 0);

        // SET_DAY ignores day_tick; mode+inc together: mode wins
        mode(1);
        tick();
        check("sd_tick_day",   day, 28);
        check("sd_tick_month", month, 2);
        check("sd_tick_mt",    month_tick, 0);
        mode_btn = 1'b1; inc_btn = 1'b1;
        cycle();
        mode_btn = 1'b0; inc_btn = 1'b0;
        check("mi_field", edit_field, 2);
        check("mi_day",   day, 28);
        check("mi_month", month, 2);
        mode(2);
        check("mi_run", edit_field, 0);

        // RUN: tick and mode on the same edge (Feb 28 2001 -> Mar 1)
        day_tick = 1'b1; mode_btn = 1'b1;
        cycle();
        day_tick = 1'b0; mode_btn = 1'b0;
        check("tm_day",   day, 1);
        check("tm_month", month, 3);
        check("tm_mt",    month_tick, 1);
        check("tm_field", edit_field, 1);

        // en=0 freezes everything
        en = 1'b0; day_tick = 1'b1; inc_btn = 1'b1; mode_btn = 1'b1;
        cycle(); cycle(); cycle();
        check("en0_day",   day, 1);
        check("en0_month", month, 3);
        check("en0_year",  year, 1);
        check("en0_field", edit_field, 1);
        check("en0_mt",    month_tick, 0);
        check("en0_yt",    year_tick, 0);
        en = 1'b1; day_tick = 1'b0; inc_btn = 1'b0; mode_btn = 1'b0;

        // Reset aborts SET_YEAR mid-edit
        mode(2);
        check("sy_field", edit_field, 3);
        inc(1);
        check("sy_year", year, 2);
        do_reset();
        check("ab_day",   day, 1);
        check("ab_month", month, 1);
        check("ab_year",  year, 0);
        check("ab_set",   set_mode, 0);
        check("ab_field", edit_field, 0);
        check("ab_mt",    month_tick, 0);

        // Set-mode wraps: day 31 -> 1 in January, month 12 -> 1
        mode(1);
        inc(31);
        check("wrap_day", day, 1);
        mode(1);
        inc(12);
        check("wrap_month", month, 1);
        check("wrap_mt",    month_tick, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
